// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared sizing constants and types for the register scoreboard
package reg_scoreboard_pkg;
    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int CNT_W    = 2;
    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one per-register in-flight write counter with busy and underflow flags
module sb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_underflow
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] w_next;

    // Simultaneous inc and dec cancel, so neither boundary check applies then.
    always_comb begin
        w_next = r_cnt;
        if (i_clr) begin
            w_next = '0;
        end else if (i_inc && !i_dec && (r_cnt != MAX_CNT)) begin
            w_next = r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            w_next = r_cnt - CNT_W'(1);
        end
    end

    assign o_underflow = i_dec & ~i_inc & ~i_clr & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_next;
            r_busy <= (w_next != '0);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = r_busy;
endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - RAW/saturation hazard scoreboard between decode and writeback
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_reg_write,
    input  logic [REG_W-1:0]    issue_rd,
    input  logic [REG_W-1:0]    issue_rs,
    input  logic                issue_rs_valid,
    input  logic [REG_W-1:0]    issue_rt,
    input  logic                issue_rt_valid,
    input  logic                wb_valid,
    input  logic                wb_reg_write,
    input  logic [REG_W-1:0]    wb_rd,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err
);
    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_underflow;
    logic [NUM_REGS-1:0] w_inc_oh;
    logic [NUM_REGS-1:0] w_dec_oh;
    logic                w_stall;
    logic                w_inc;
    logic                w_dec;
    logic                r_err;

    // Hazards look only at registered counts; a retire frees the operand next cycle.
    assign w_stall = issue_valid & ~flush &
                     ((issue_rs_valid & (w_cnt[issue_rs] != '0)) |
                      (issue_rt_valid & (w_cnt[issue_rt] != '0)) |
                      (issue_reg_write & (w_cnt[issue_rd] == MAX_CNT)));

    assign w_inc = issue_valid & ~w_stall & issue_reg_write & ~flush;
    assign w_dec = wb_valid & wb_reg_write & ~flush;

    always_comb begin
        w_inc_oh = '0;
        w_dec_oh = '0;
        w_inc_oh[issue_rd] = w_inc;
        w_dec_oh[wb_rd]    = w_dec;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        sb_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc_oh[g]),
            .i_dec       (w_dec_oh[g]),
            .i_clr       (flush),
            .o_cnt       (w_cnt[g]),
            .o_busy      (w_busy[g]),
            .o_underflow (w_underflow[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_underflow);
        end
    end

    assign stall     = w_stall;
    assign busy_mask = w_busy;
    assign err       = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed table plus randomized model check of reg_scoreboard
module tb_reg_scoreboard;
    typedef struct packed {
        bit       rst;
        bit       iv;
        bit       irw;
        bit [2:0] rd;
        bit [2:0] rs;
        bit       rsv;
        bit [2:0] rt;
        bit       rtv;
        bit       wv;
        bit       wrw;
        bit [2:0] wrd;
        bit       fl;
        bit       e_stall;
        bit [7:0] e_busy;
        bit       e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0, issue_reg_write = 1'b0;
    logic [2:0] issue_rd = '0, issue_rs = '0, issue_rt = '0, wb_rd = '0;
    logic       issue_rs_valid = 1'b0, issue_rt_valid = 1'b0;
    logic       wb_valid = 1'b0, wb_reg_write = 1'b0, flush = 1'b0;
    logic       stall;
    logic [7:0] busy_mask;
    logic       err;

    int checks = 0;
    int errors = 0;
    int m_cnt [8];
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_reg_write (issue_reg_write),
        .issue_rd        (issue_rd),
        .issue_rs        (issue_rs),
        .issue_rs_valid  (issue_rs_valid),
        .issue_rt        (issue_rt),
        .issue_rt_valid  (issue_rt_valid),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .stall           (stall),
        .busy_mask       (busy_mask),
        .err             (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit iv, bit irw, bit [2:0] rd, bit [2:0] rs, bit rsv,
                                bit [2:0] rt, bit rtv, bit wv, bit wrw, bit [2:0] wrd, bit fl,
                                bit es, bit [7:0] eb, bit ee);
        return '{r, iv, irw, rd, rs, rsv, rt, rtv, wv, wrw, wrd, fl, es, eb, ee};
    endfunction

    function automatic bit model_stall(vec_t v);
        if (!v.iv || v.fl) return 1'b0;
        return (v.rsv && m_cnt[v.rs] != 0) || (v.rtv && m_cnt[v.rt] != 0) ||
               (v.irw && m_cnt[v.rd] == 3);
    endfunction

    function automatic bit [7:0] model_busy();
        bit [7:0] b = '0;
        for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_update(input vec_t v, input bit ms);
        bit inc, dec;
        if (v.rst) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else if (v.fl) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        end else begin
            inc = v.iv && !ms && v.irw;
            dec = v.wv && v.wrw;
            if (!(inc && dec && v.rd == v.wrd)) begin
                if (inc) m_cnt[v.rd]++;
                if (dec) begin
                    if (m_cnt[v.wrd] == 0) m_err = 1'b1;
                    else m_cnt[v.wrd]--;
                end
            end
        end
    endtask

    // Called at a negedge: drive, sample stall, cross the posedge, sample registered outputs.
    task automatic step(input vec_t v, output logic a_stall, output logic [7:0] a_busy,
                        output logic a_err, output bit m_stall);
        rst = v.rst; issue_valid = v.iv; issue_reg_write = v.irw; issue_rd = v.rd;
        issue_rs = v.rs; issue_rs_valid = v.rsv; issue_rt = v.rt; issue_rt_valid = v.rtv;
        wb_valid = v.wv; wb_reg_write = v.wrw; wb_rd = v.wrd; flush = v.fl;
        #1;
        a_stall = stall;
        m_stall = model_stall(v);
        @(posedge clk);
        model_update(v, m_stall);
        #1;
        a_busy = busy_mask;
        a_err  = err;
        @(negedge clk);
    endtask

    function automatic vec_t rand_vec(bit force_rst);
        vec_t v;
        v = vec_t'({$urandom, $urandom});
        v.rst = force_rst ? 1'b1 : ($urandom_range(63) == 0);
        v.fl  = ($urandom_range(31) == 0);
        return v;
    endfunction

    vec_t       dir [33];
    vec_t       v;
    logic       a_stall, a_err;
    logic [7:0] a_busy;
    bit         ms;

    initial begin
        dir[0]  = mk(0,1,1,3,0,0,0,0,0,0,0,0, 0,8'h08,0);
        dir[1]  = mk(0,1,0,0,3,1,0,0,0,0,0,0, 1,8'h08,0);
        dir[2]  = mk(0,1,0,0,0,0,3,1,0,0,0,0, 1,8'h08,0);
        dir[3]  = mk(0,1,0,0,3,1,0,0,1,1,3,0, 1,8'h00,0);
        dir[4]  = mk(0,1,0,0,3,1,0,0,0,0,0,0, 0,8'h00,0);
        dir[5]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 0,8'h20,0);
        dir[6]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 0,8'h20,0);
        dir[7]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 0,8'h20,0);
        dir[8]  = mk(0,1,1,5,0,0,0,0,0,0,0,0, 1,8'h20,0);
        dir[9]  = mk(0,1,1,5,0,0,0,0,1,1,5,0, 1,8'h20,0);
        dir[10] = mk(0,1,1,5,0,0,0,0,0,0,0,0, 0,8'h20,0);
        dir[11] = mk(0,0,0,0,0,0,0,0,1,1,5,0, 0,8'h20,0);
        dir[12] = mk(0,0,0,0,0,0,0,0,1,1,5,0, 0,8'h20,0);
        dir[13] = mk(0,0,0,0,0,0,0,0,1,1,5,0, 0,8'h00,0);
        dir[14] = mk(0,1,1,2,0,0,0,0,0,0,0,0, 0,8'h04,0);
        dir[15] = mk(0,1,1,2,0,0,0,0,1,1,2,0, 0,8'h04,0);
        dir[16] = mk(0,0,0,0,0,0,0,0,1,1,2,0, 0,8'h00,0);
        dir[17] = mk(0,1,1,0,0,0,0,0,1,1,0,0, 0,8'h00,0);
        dir[18] = mk(0,0,0,0,0,0,0,0,1,1,6,0, 0,8'h00,1);
        dir[19] = mk(0,1,1,1,0,0,0,0,0,0,0,1, 0,8'h00,1);
        dir[20] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,8'h00,1);
        dir[21] = mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,8'h00,0);
        dir[22] = mk(0,1,1,1,0,0,0,0,0,0,0,0, 0,8'h02,0);
        dir[23] = mk(0,1,1,1,0,0,0,0,0,0,0,0, 0,8'h02,0);
        dir[24] = mk(0,1,1,4,0,0,0,0,0,0,0,0, 0,8'h12,0);
        dir[25] = mk(0,1,1,7,1,1,0,0,0,0,0,1, 0,8'h00,0);
        dir[26] = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,8'h00,0);
        dir[27] = mk(0,1,1,3,0,0,0,0,0,0,0,0, 0,8'h08,0);
        dir[28] = mk(1,1,0,0,3,1,0,0,0,0,0,0, 1,8'h00,0);
        dir[29] = mk(0,1,0,0,3,1,0,0,0,0,0,0, 0,8'h00,0);
        dir[30] = mk(0,1,1,1,0,0,0,0,0,0,0,0, 0,8'h02,0);
        dir[31] = mk(0,1,1,2,0,0,0,0,1,1,1,0, 0,8'h04,0);
        dir[32] = mk(0,0,0,0,0,0,0,0,1,1,5,1, 0,8'h00,0);

        @(negedge clk);

        for (int c = 0; c < 2; c++) begin
            v = rand_vec(1'b1);
            step(v, a_stall, a_busy, a_err, ms);
            if (c == 1) chk("reset_stall", a_stall, 0);
            chk("reset_busy", a_busy, 0);
            chk("reset_err", a_err, 0);
        end

        for (int i = 0; i < 33; i++) begin
            step(dir[i], a_stall, a_busy, a_err, ms);
            chk($sformatf("dir%0d_stall", i), a_stall, dir[i].e_stall);
            chk($sformatf("dir%0d_busy", i), a_busy, dir[i].e_busy);
            chk($sformatf("dir%0d_err", i), a_err, dir[i].e_err);
        end

        for (int i = 0; i < 400; i++) begin
            v = rand_vec(1'b0);
            step(v, a_stall, a_busy, a_err, ms);
            chk($sformatf("rnd%0d_stall", i), a_stall, ms);
            chk($sformatf("rnd%0d_busy", i), a_busy, model_busy());
            chk($sformatf("rnd%0d_err", i), a_err, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
